arbiter: RTL and testbench

ARBITER -- requirements
Module: arbiter

---
 rtl/arbiter_pkg.sv | 26 ++
 rtl/arbiter_rr_pick.sv | 27 ++
 rtl/arbiter.sv | 101 ++++++++++
 tb/tb_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the three-requester round-robin arbiter.
package arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GNT2 = 2'd3
  } state_t;

  // Successor of a requester index, wrapping 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic state_t gnt_state(input logic [1:0] i);
    case (i)
      2'd0:    return GNT0;
      2'd1:    return GNT1;
      default: return GNT2;
    endcase
  endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin picker: scans LAST+1, LAST+2, LAST (mod 3) and
// reports the first requesting index.
module rr_pick
  import arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         idx,
  output logic               vld
);

  logic [1:0] cand;

  always_comb begin
    idx  = 2'd0;
    vld  = 1'b0;
    cand = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_next(cand);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/arbiter.sv
// Three-way non-preemptive round-robin arbiter with registered one-hot grants
// and an optional hold limit (MAX_HOLD = 0 means a holder keeps the grant).
module arbiter
  import arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic r0,
  input  logic r1,
  input  logic r2,
  output logic g0,
  output logic g1,
  output logic g2
);

  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

  state_t          state, nxt;
  logic [1:0]      last, nxt_last;
  logic [HW-1:0]   hold, nxt_hold;
  logic [2:0]      req, cur_mask, pick_req;
  logic [1:0]      pick_idx;
  logic            pick_vld;
  logic            cur_req, others, expire;

  assign req = {r2, r1, r0};

  always_comb begin
    cur_mask = 3'b000;
    case (state)
      GNT0:    cur_mask = 3'b001;
      GNT1:    cur_mask = 3'b010;
      GNT2:    cur_mask = 3'b100;
      default: cur_mask = 3'b000;
    endcase
  end

  assign cur_req = |(req & cur_mask);
  assign others  = |(req & ~cur_mask);
  assign expire  = (MAX_HOLD > 0) && (hold >= HOLD_LIM);

  // A holder whose limit has run out is masked so the picker moves on.
  assign pick_req = (cur_req && expire) ? (req & ~cur_mask) : req;

  rr_pick u_pick (
    .req  (pick_req),
    .last (last),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  always_comb begin
    nxt      = state;
    nxt_last = last;
    nxt_hold = hold;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          nxt      = gnt_state(pick_idx);
          nxt_last = pick_idx;
          nxt_hold = (MAX_HOLD > 0) ? HW'(1) : '0;
        end
      end
      default: begin
        if (cur_req && !(expire && others)) begin
          if ((MAX_HOLD > 0) && (hold < HOLD_LIM))
            nxt_hold = hold + HW'(1);
        end else if (pick_vld) begin
          nxt      = gnt_state(pick_idx);
          nxt_last = pick_idx;
          nxt_hold = (MAX_HOLD > 0) ? HW'(1) : '0;
        end else begin
          nxt      = IDLE;
          nxt_hold = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 2'd2;
      hold  <= '0;
      g0    <= 1'b0;
      g1    <= 1'b0;
      g2    <= 1'b0;
    end else begin
      state <= nxt;
      last  <= nxt_last;
      hold  <= nxt_hold;
      g0    <= (nxt == GNT0);
      g1    <= (nxt == GNT1);
      g2    <= (nxt == GNT2);
    end
  end

endmodule

// File: tb/tb_arbiter.sv
// Bench for arbiter: directed vector table, hold-limit sequences, and random
// traffic against a behavioural round-robin model for two parameterisations.
module tb_arbiter;

  logic clk, reset, r0, r1, r2;
  logic a_g0, a_g1, a_g2;
  logic h_g0, h_g1, h_g2;

  int tests = 0;
  int fails = 0;

  arbiter u_arb (
    .clk(clk), .reset(reset), .r0(r0), .r1(r1), .r2(r2),
    .g0(a_g0), .g1(a_g1), .g2(a_g2)
  );

  arbiter #(.MAX_HOLD(2)) u_hold (
    .clk(clk), .reset(reset), .r0(r0), .r1(r1), .r2(r2),
    .g0(h_g0), .g1(h_g1), .g2(h_g2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: current holder (-1 = none), last winner, cycles held.
  int mcur[2], mlast[2], mhold[2];
  int mlim[2] = '{0, 2};

  function automatic int rr_choose(input bit [2:0] rq, input int lst);
    for (int k = 1; k <= 3; k++) begin
      int n = (lst + k) % 3;
      if (rq[n]) return n;
    end
    return -1;
  endfunction

  task automatic model_step(input int m, input bit rst, input bit [2:0] rq);
    bit [2:0] cand;
    int n;
    bit keep;
    if (rst) begin
      mcur[m] = -1; mlast[m] = 2; mhold[m] = 0;
      return;
    end
    keep = 1'b0;
    cand = rq;
    if (mcur[m] >= 0 && rq[mcur[m]]) begin
      bit [2:0] rest = rq & ~(3'b001 << mcur[m]);
      if (mlim[m] > 0 && mhold[m] >= mlim[m] && rest != 0)
        cand = rest;
      else
        keep = 1'b1;
    end
    if (keep) begin
      if (mhold[m] < mlim[m]) mhold[m]++;
    end else begin
      n = rr_choose(cand, mlast[m]);
      if (n >= 0) begin
        mcur[m] = n; mlast[m] = n; mhold[m] = 1;
      end else begin
        mcur[m] = -1; mhold[m] = 0;
      end
    end
  endtask

  function automatic bit [2:0] model_g(input int m);
    return (mcur[m] < 0) ? 3'b000 : (3'b001 << mcur[m]);
  endfunction

  task automatic check(input string name, input bit [2:0] act, input bit [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got g=%b expected g=%b", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, advance the model, sample 1 time unit later.
  task automatic step(input bit rst, input bit [2:0] rq);
    reset = rst;
    {r2, r1, r0} = rq;
    @(posedge clk);
    model_step(0, rst, rq);
    model_step(1, rst, rq);
    #1;
  endtask

  typedef struct {
    bit       rst;
    bit [2:0] r;
    bit [2:0] g;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1; r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;

    // {reset, {r2,r1,r0}, expected {g2,g1,g0} after that edge}
    vecs.push_back('{1, 3'b000, 3'b000});
    vecs.push_back('{0, 3'b000, 3'b000});
    vecs.push_back('{0, 3'b000, 3'b000});
    vecs.push_back('{0, 3'b001, 3'b001});
    vecs.push_back('{0, 3'b000, 3'b000});
    vecs.push_back('{0, 3'b010, 3'b010});
    vecs.push_back('{0, 3'b000, 3'b000});
    vecs.push_back('{0, 3'b100, 3'b100});
    vecs.push_back('{0, 3'b000, 3'b000});
    vecs.push_back('{0, 3'b111, 3'b001});
    vecs.push_back('{0, 3'b110, 3'b010});
    vecs.push_back('{0, 3'b110, 3'b010});
    vecs.push_back('{0, 3'b100, 3'b100});
    vecs.push_back('{0, 3'b100, 3'b100});
    vecs.push_back('{0, 3'b000, 3'b000});
    vecs.push_back('{0, 3'b010, 3'b010});
    vecs.push_back('{1, 3'b010, 3'b000});
    vecs.push_back('{0, 3'b011, 3'b001});
    vecs.push_back('{0, 3'b000, 3'b000});
    vecs.push_back('{1, 3'b111, 3'b000});
    vecs.push_back('{0, 3'b000, 3'b000});
    vecs.push_back('{0, 3'b100, 3'b100});
    vecs.push_back('{0, 3'b011, 3'b001});
    vecs.push_back('{0, 3'b011, 3'b001});
    vecs.push_back('{0, 3'b010, 3'b010});
    vecs.push_back('{0, 3'b000, 3'b000});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].r);
      check($sformatf("vec%0d_nohold", i), {a_g2, a_g1, a_g0}, vecs[i].g);
      check($sformatf("vec%0d_hold2", i), {h_g2, h_g1, h_g0}, vecs[i].g);
    end

    // Two requesters held high: unlimited keeps g0, limit 2 alternates 2+2.
    begin
      bit [2:0] exp_h[6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b001, 3'b001};
      step(1'b1, 3'b000);
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 3'b011);
        check($sformatf("share%0d_nohold", i), {a_g2, a_g1, a_g0}, 3'b001);
        check($sformatf("share%0d_hold2", i), {h_g2, h_g1, h_g0}, exp_h[i]);
      end
    end

    // Lone holder saturates its counter, then yields at once when r1 arrives.
    step(1'b1, 3'b000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b001);
      check($sformatf("sat%0d_hold2", i), {h_g2, h_g1, h_g0}, 3'b001);
    end
    step(1'b0, 3'b011);
    check("sat_yield_hold2", {h_g2, h_g1, h_g0}, 3'b010);
    check("sat_keep_nohold", {a_g2, a_g1, a_g0}, 3'b001);

    // Random traffic with sticky requests so holds and hand-offs occur.
    begin
      bit [2:0] rq = 3'b000;
      bit rst;
      step(1'b1, 3'b000);
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
        rst = ($urandom_range(0, 59) == 0);
        step(rst, rq);
        check($sformatf("rnd%0d_nohold", i), {a_g2, a_g1, a_g0}, model_g(0));
        check($sformatf("rnd%0d_hold2", i), {h_g2, h_g1, h_g0}, model_g(1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
